// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered hex value,
// blank-before-digit sequencing, leading-zero blanking and selectable enable polarity.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 2,
    parameter int SCAN_CLKS     = 25000,
    parameter int BLANK_CLKS    = 250,
    parameter bit ACTIVE_LOW_EN = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Valid,
    output logic                    o_Ready,
    input  logic                    i_LZB,
    output logic [3:0]              o_Nibble,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Blank,
    output logic                    o_Frame_Done
);

    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CLKS = (SCAN_CLKS > BLANK_CLKS) ? SCAN_CLKS : BLANK_CLKS;
    localparam int CNT_W    = $clog2(MAX_CLKS + 1);

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      SCAN_LAST  = CNT_W'(SCAN_CLKS - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CLKS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_IDLE    = {NUM_DIGITS{ACTIVE_LOW_EN}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_full;

    state_t                  state_nx;
    logic [IDX_W-1:0]        idx_nx;
    logic [CNT_W-1:0]        cnt_nx;
    logic [4*NUM_DIGITS-1:0] display_nx;
    logic [4*NUM_DIGITS-1:0] pending_nx;
    logic                    full_nx;
    logic                    frame_end;
    logic                    lit_nx;

    function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] v,
                                             input logic [IDX_W-1:0]        k);
        return v[4*k +: 4];
    endfunction

    // Digit k>0 goes dark when it and every more significant digit are zero.
    function automatic logic is_suppressed(input logic [4*NUM_DIGITS-1:0] v,
                                           input logic [IDX_W-1:0]        k,
                                           input logic                    lzb);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int d = 1; d < NUM_DIGITS; d++) begin
            if (d >= int'(k) && v[4*d +: 4] != 4'h0) upper_zero = 1'b0;
        end
        return lzb && (k != '0) && upper_zero;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] enable_for(input logic [IDX_W-1:0] k);
        logic [NUM_DIGITS-1:0] onehot;
        onehot    = '0;
        onehot[k] = 1'b1;
        return onehot ^ EN_IDLE;
    endfunction

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        cnt_nx     = cnt + CNT_W'(1);
        display_nx = display;
        pending_nx = pending;
        full_nx    = pending_full;
        frame_end  = (state == ST_SHOW) && (idx == LAST_IDX) && (cnt == SCAN_LAST);

        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nx = ST_SHOW;
                    cnt_nx   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == SCAN_LAST) begin
                    state_nx = ST_BLANK;
                    cnt_nx   = '0;
                    idx_nx   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                end
            end
        endcase

        // Ready is low whenever pending is full, so commit and accept never collide.
        if (frame_end && pending_full) begin
            display_nx = pending;
            full_nx    = 1'b0;
        end
        if (i_Valid && o_Ready) begin
            pending_nx = i_Value;
            full_nx    = 1'b1;
        end

        lit_nx = (state_nx == ST_SHOW) && !is_suppressed(display_nx, idx_nx, i_LZB);
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= ST_BLANK;
            idx          <= '0;
            cnt          <= '0;
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            o_Ready      <= 1'b1;
            o_Nibble     <= 4'h0;
            o_Digit_En   <= EN_IDLE;
            o_Blank      <= 1'b1;
            o_Frame_Done <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            cnt          <= cnt_nx;
            display      <= display_nx;
            pending      <= pending_nx;
            pending_full <= full_nx;
            o_Ready      <= !full_nx;
            o_Nibble     <= nibble_at(display_nx, idx_nx);
            o_Digit_En   <= lit_nx ? enable_for(idx_nx) : EN_IDLE;
            o_Blank      <= !lit_nx;
            o_Frame_Done <= (state_nx == ST_SHOW) && (idx_nx == LAST_IDX) &&
                            (cnt_nx == SCAN_LAST);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized scoreboard bench: a frame-arithmetic reference model predicts every
// output cycle of two instances that differ only in enable polarity.
module tb_seven_seg_scan_ctrl;

    localparam int N     = 2;
    localparam int S     = 4;
    localparam int B     = 2;
    localparam int PER   = B + S;
    localparam int FRAME = N * PER;
    localparam int NCYC  = 4000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         lzb = 1'b0;
    logic [4*N-1:0] value = '0;

    logic         a_ready, a_blank, a_fd;
    logic [3:0]   a_nib;
    logic [N-1:0] a_en;
    logic         b_ready, b_blank, b_fd;
    logic [3:0]   b_nib;
    logic [N-1:0] b_en;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_CLKS(S), .BLANK_CLKS(B), .ACTIVE_LOW_EN(1'b0)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Value(value), .i_Valid(valid), .o_Ready(a_ready),
        .i_LZB(lzb), .o_Nibble(a_nib), .o_Digit_En(a_en), .o_Blank(a_blank),
        .o_Frame_Done(a_fd)
    );

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_CLKS(S), .BLANK_CLKS(B), .ACTIVE_LOW_EN(1'b1)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Value(value), .i_Valid(valid), .o_Ready(b_ready),
        .i_LZB(lzb), .o_Nibble(b_nib), .o_Digit_En(b_en), .o_Blank(b_blank),
        .o_Frame_Done(b_fd)
    );

    typedef struct packed {
        logic [3:0]   nib;
        logic [N-1:0] en;
        logic         blank;
        logic         fd;
        logic         ready;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   out_cycle  = 0;

    // Expected outputs for cycle tt of a frame, from position arithmetic alone.
    function automatic exp_t expect_at(input int tt, input int dv, input bit lz, input bit rdy);
        int   p;
        int   dig;
        int   w;
        bit   show;
        bit   supp;
        exp_t e;
        p     = tt % FRAME;
        dig   = p / PER;
        w     = p % PER;
        show  = (w >= B);
        supp  = lz && (dig > 0) && ((dv >> (4 * dig)) == 0);
        e.nib   = 4'((dv >> (4 * dig)) & 15);
        e.en    = (show && !supp) ? N'(1 << dig) : '0;
        e.blank = !(show && !supp);
        e.fd    = (dig == N - 1) && (w == PER - 1);
        e.ready = rdy;
        return e;
    endfunction

    initial begin : driver
        int t;
        int disp;
        int pend;
        bit full;
        bit ready_m;
        bit fd_now;
        t = 0; disp = 0; pend = 0; full = 1'b0; ready_m = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            rst   = (c < 3) || ($urandom_range(0, 399) == 0);
            valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0:       value = 8'h00;
                1:       value = 8'h07;
                2:       value = 8'h3A;
                default: value = 8'($urandom);
            endcase
            if ($urandom_range(0, 29) == 0) lzb = ~lzb;

            if (rst) begin
                t = 0; disp = 0; full = 1'b0; ready_m = 1'b1;
            end else begin
                fd_now = ((t % FRAME) == FRAME - 1);
                if (fd_now && full) begin
                    disp = pend;
                    full = 1'b0;
                end
                if (valid && ready_m) begin
                    pend = int'(value);
                    full = 1'b1;
                end
                t++;
                ready_m = !full;
            end
            q.push_back(expect_at(t, disp, lzb, ready_m));
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        @(negedge clk);
        #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d expectations left, need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = '{nib: a_nib, en: a_en, blank: a_blank, fd: a_fd, ready: a_ready};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL scan_hi cycle %0d: got nib=%h en=%b blank=%b fd=%b rdy=%b, need nib=%h en=%b blank=%b fd=%b rdy=%b",
                         out_cycle, a_nib, a_en, a_blank, a_fd, a_ready,
                         e.nib, e.en, e.blank, e.fd, e.ready);
            end
            e.en = e.en ^ {N{1'b1}};
            got = '{nib: b_nib, en: b_en, blank: b_blank, fd: b_fd, ready: b_ready};
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL scan_lo cycle %0d: got nib=%h en=%b blank=%b fd=%b rdy=%b, need nib=%h en=%b blank=%b fd=%b rdy=%b",
                         out_cycle, b_nib, b_en, b_blank, b_fd, b_ready,
                         e.nib, e.en, e.blank, e.fd, e.ready);
            end
            out_cycle++;
        end
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode/cathode seven-segment display.
- Accepts a packed hex value over a valid/ready handshake and double-buffers it, so updates apply only at frame boundaries (no torn frames).
- Sequences digit enables with an anti-ghosting blank interval before each digit.
- Feeds the current 4-bit nibble to the downstream registered hex-to-segment decoder.

Parameters:
NUM_DIGITS, 2, number of digits scanned (legal 2..4)
SCAN_CLKS, 25000, clocks each digit is enabled (>=1)
BLANK_CLKS, 250, clocks all digits are off before each digit (>=2; covers 1-cycle decoder latency)
ACTIVE_LOW_EN, 1, 1 = digit enables active-low, 0 = active-high

Ports:
i_Clk  input  1  system clock; all logic on rising edge
i_Rst  input  1  synchronous, active-high reset
i_Value  input  4*NUM_DIGITS  packed hex digits; nibble 0 = least significant digit
i_Valid  input  1  i_Value valid
o_Ready  output  1  controller can accept a value
i_LZB  input  1  leading-zero blanking enable (sampled live)
o_Nibble  output  4  nibble for decoder's i_Binary_Num
o_Digit_En  output  NUM_DIGITS  one-hot digit enables (polarity per ACTIVE_LOW_EN)
o_Blank  output  1  1 when no digit is enabled
o_Frame_Done  output  1  one-cycle pulse on last cycle of each frame

Behaviour:
- Reset (i_Rst high at an edge), effective the next cycle:
  - state BLANK; idx 0; counter 0; display reg 0; pending empty.
  - o_Ready 1; o_Digit_En all inactive; o_Nibble 0; o_Blank 1; o_Frame_Done 0.
  - Reset mid-operation discards any pending value.
- FSM states: BLANK and SHOW.
  - BLANK lasts BLANK_CLKS cycles; all enables inactive; o_Blank 1.
  - BLANK then goes to SHOW, which lasts SCAN_CLKS cycles; enable bit idx active unless suppressed; o_Blank = suppressed.
  - SHOW then goes to BLANK with idx+1, wrapping NUM_DIGITS-1 -> 0.
  - Counter resets to 0 at every state change.
- Frame:
  - Length = NUM_DIGITS*(BLANK_CLKS+SCAN_CLKS) cycles.
  - o_Frame_Done high on the final SHOW cycle of idx NUM_DIGITS-1.
- o_Nibble:
  - Equals display_reg nibble[idx] in both states, so the value is present throughout the preceding BLANK and the decoder settles before the enable asserts.
  - Driven only from registers; no combinational path from inputs.
- Handshake:
  - A transfer occurs when i_Valid && o_Ready at a rising edge; i_Value is captured into pending and o_Ready is 0 from the next cycle.
  - i_Valid while o_Ready=0 is ignored; the source must hold.
  - Commit: at the edge ending the o_Frame_Done cycle, pending moves to display_reg and pending clears.
  - o_Ready returns to 1 in the first BLANK cycle of the new frame.
  - Accept and commit can never coincide, because o_Ready=0 whenever pending is full.
  - With an empty pending buffer, display_reg is unchanged.
- Leading-zero blanking:
  - With i_LZB=1, digit k>0 is suppressed when display nibbles k..NUM_DIGITS-1 are all zero.
  - While suppressed, its enable stays inactive through SHOW and o_Blank stays 1.
  - Digit 0 is never suppressed; timing is unchanged by suppression.
- Enable polarity:
  - Inactive level = ACTIVE_LOW_EN.
  - Active bit = ~ACTIVE_LOW_EN; all other bits stay inactive.

Test Plan:
Scenarios use NUM_DIGITS=2, SCAN_CLKS=4, BLANK_CLKS=2, ACTIVE_LOW_EN=0 unless stated. Cycle 0 = first cycle after reset release.
1. Reset release, no load:
   - o_Digit_En: 00 at cycles 0-1, 01 at cycles 2-5, 00 at 6-7, 10 at 8-11.
   - o_Frame_Done=1 only at cycles 11 and 23.
   - o_Nibble=0 throughout; o_Blank=1 at cycles 0-1 and 6-7.
2. Load 0x3A at cycle 1 (i_Valid one cycle):
   - o_Ready=0 at cycles 2-11, 1 from cycle 12.
   - Cycles 0-11 display 0.
   - From cycle 12: o_Nibble=A with enable 01 at cycles 14-17; o_Nibble=3 with enable 10 at cycles 20-23.
3. Back-pressure:
   - Load 0x3A at cycle 1, then hold i_Valid=1 with 0x55 from cycle 2.
   - 0x55 is not taken until o_Ready=1 at cycle 12 (accepted at cycle 12).
   - 0x55 is displayed from cycle 24; 0x3A is shown for exactly one frame.
4. Leading-zero blanking:
   - With display 0x07 and i_LZB=1: enable stays 00 and o_Blank=1 during the digit-1 SHOW; digit 0 shows 7.
   - With i_LZB=0: digit 1 is enabled with o_Nibble=0.
   - With display 0x00 and i_LZB=1: digit 0 is still enabled.
5. Reset mid-operation:
   - Pulse i_Rst at cycle 9, during digit-1 SHOW with display 0x3A and a pending value.
   - Cycle 10: all reset values; pending lost; scan restarts at BLANK of idx 0.
6. ACTIVE_LOW_EN=1:
   - Idle enables are 11; digit 0 active gives 10, digit 1 active gives 01.
   - Suppressed digit gives 11.
